psk_freq_search: RTL
====================

PSK_FREQ_SEARCH -- requirements
Module: psk_freq_search

Interface
REQ-001 Parameter FCW_START, default 12'h0C0, first frequency control word of the sweep.
REQ-002 Parameter FCW_STEP, default 12'h010, increment between sweep points.
REQ-003 Parameter NUM_STEPS, default 16 (range 1..255), number of sweep points.
REQ-004 Parameter LOCK_THRESH, default 17'h04000, minimum peak energy to declare lock.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_in_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle request to begin a sweep.
REQ-008 stb  input  1  one-cycle pulse: i_value/q_value hold a completed correlation window.
REQ-009 i_value  input  8  unsigned in-phase correlator count, valid when stb=1.
REQ-010 q_value  input  8  unsigned quadrature correlator count, valid when stb=1.
REQ-011 fcw  output  12  frequency control word driven to the I/Q NCOs.
REQ-012 busy  output  1  high while a sweep is in progress.
REQ-013 done  output  1  high while the sweep result is valid.
REQ-014 locked  output  1  high when done=1 and best_energy >= LOCK_THRESH.
REQ-015 best_fcw  output  12  fcw of the highest-energy sweep point.
REQ-016 best_energy  output  17  energy of that point.

Function
REQ-017 Energy = i_value*i_value + q_value*q_value, computed at full 17-bit width with no truncation.
REQ-018 The FSM shall have states IDLE, SETTLE, MEASURE, NEXT, DONE.
REQ-019 IDLE: fcw=FCW_START, busy=0, done=0; start=1 -> SETTLE; the same edge clears best_energy to 0, sets best_fcw=FCW_START and step counter=0.
REQ-020 SETTLE: the first stb is discarded (window straddled an fcw change) -> MEASURE.
REQ-021 MEASURE: on stb, if energy > best_energy (strict), best_energy/best_fcw update on that same edge to energy/current fcw; state -> NEXT.
REQ-022 NEXT (exactly one cycle): step=NUM_STEPS-1 -> DONE with fcw<=best_fcw; otherwise fcw<=fcw+FCW_STEP modulo 4096, step++, -> SETTLE.
REQ-023 Equal energies: the earliest sweep point is retained.
REQ-024 DONE: done=1, busy=0, fcw holds best_fcw; locked is a registered output valid from the first DONE cycle.
REQ-025 start=1 in DONE restarts exactly as REQ-019 (done and locked drop on that edge); otherwise DONE persists indefinitely.
REQ-026 start in SETTLE, MEASURE or NEXT is ignored.
REQ-027 stb in IDLE, NEXT or DONE is ignored.
REQ-028 busy=1 in SETTLE, MEASURE and NEXT.
REQ-029 Sweep length equals 2*NUM_STEPS stb pulses plus NUM_STEPS NEXT cycles.
REQ-030 fcw wrap-around past 12'hFFF is permitted and does not terminate the sweep.

Reset
REQ-031 rst_in_n=0 asynchronously forces IDLE: fcw=FCW_START, busy=0, done=0, locked=0, best_fcw=FCW_START, best_energy=0, step=0.
REQ-032 Reset asserted mid-sweep aborts it with no partial result retained; after release the block waits for a new start.
REQ-033 Deassertion shall be synchronised so the FSM leaves reset on a clean clock edge.

Verification
REQ-034 Peak at step 5: stb data i=q=10 everywhere except step 5 i=200,q=0 -> done=1, best_fcw=12'h110, best_energy=40000, locked=1, fcw=12'h110.
REQ-035 Flat low input: all points i=q=50 -> best_fcw=12'h0C0 (first point kept), best_energy=5000, locked=0.
REQ-036 Settle discard: SETTLE stb with i=q=255, MEASURE stb with i=q=1 at every point -> best_energy=2.
REQ-037 Wrap: FCW_START=12'hFF0, FCW_STEP=12'h010, NUM_STEPS=3 -> fcw sequence FF0, 000, 010; then done=1.
REQ-038 Reset mid-sweep: assert rst_in_n=0 at step 7 -> outputs at reset values immediately; with no start, fcw stays FCW_START and busy=0.
REQ-039 Restart from DONE: pulse start -> done=0, busy=1, best_energy=0 on next edge; start pulses during the sweep do not alter the step count.

Source files
------------

// File: rtl/psk_freq_search_if.sv
// Correlator/NCO bundle for the frequency sweep: stimulus and start request in,
// current fcw, sweep status and the best sweep point out.
interface psk_freq_search_if;
    logic        start;
    logic        stb;
    logic [7:0]  i_value;
    logic [7:0]  q_value;
    logic [11:0] fcw;
    logic        busy;
    logic        done;
    logic        locked;
    logic [11:0] best_fcw;
    logic [16:0] best_energy;

    modport master (
        output start, stb, i_value, q_value,
        input  fcw, busy, done, locked, best_fcw, best_energy
    );

    modport slave (
        input  start, stb, i_value, q_value,
        output fcw, busy, done, locked, best_fcw, best_energy
    );
endinterface

// File: rtl/psk_freq_search.sv
// Steps the NCO fcw across NUM_STEPS points and keeps the point with peak I^2+Q^2 energy.
// Each point takes one discarded settle window, one measured window and one NEXT cycle; no backpressure.
module psk_freq_search #(
    parameter logic [11:0] FCW_START   = 12'h0C0,
    parameter logic [11:0] FCW_STEP    = 12'h010,
    parameter int unsigned NUM_STEPS   = 16,
    parameter logic [16:0] LOCK_THRESH = 17'h04000
) (
    input  logic              clk,
    input  logic              rst_in_n,
    psk_freq_search_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        NEXT    = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [7:0] LAST_STEP = 8'(NUM_STEPS - 1);

    logic [1:0]  rst_sync_q;
    logic        rst_n;
    state_t      state_q, state_d;
    logic [11:0] fcw_q, fcw_d;
    logic [7:0]  step_q, step_d;
    logic [11:0] best_fcw_q, best_fcw_d;
    logic [16:0] best_energy_q, best_energy_d;
    logic        locked_q, locked_d;
    logic [16:0] energy;

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_q[1];

    assign energy = ({9'd0, bus.i_value} * {9'd0, bus.i_value})
                  + ({9'd0, bus.q_value} * {9'd0, bus.q_value});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            fcw_q         <= FCW_START;
            step_q        <= 8'd0;
            best_fcw_q    <= FCW_START;
            best_energy_q <= 17'd0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            fcw_q         <= fcw_d;
            step_q        <= step_d;
            best_fcw_q    <= best_fcw_d;
            best_energy_q <= best_energy_d;
            locked_q      <= locked_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        fcw_d         = fcw_q;
        step_d        = step_q;
        best_fcw_d    = best_fcw_q;
        best_energy_d = best_energy_q;
        locked_d      = locked_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d       = SETTLE;
                    fcw_d         = FCW_START;
                    step_d        = 8'd0;
                    best_fcw_d    = FCW_START;
                    best_energy_d = 17'd0;
                    locked_d      = 1'b0;
                end
            end
            SETTLE: begin
                // This window straddled the fcw change, so its data is dropped.
                if (bus.stb) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (bus.stb) begin
                    state_d = NEXT;
                    // Strict compare keeps the earliest point on ties.
                    if (energy > best_energy_q) begin
                        best_energy_d = energy;
                        best_fcw_d    = fcw_q;
                    end
                end
            end
            NEXT: begin
                if (step_q == LAST_STEP) begin
                    state_d  = DONE;
                    fcw_d    = best_fcw_q;
                    locked_d = (best_energy_q >= LOCK_THRESH);
                end else begin
                    state_d = SETTLE;
                    fcw_d   = fcw_q + FCW_STEP;
                    step_d  = step_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.fcw         = fcw_q;
    assign bus.busy        = (state_q == SETTLE) || (state_q == MEASURE) || (state_q == NEXT);
    assign bus.done        = (state_q == DONE);
    assign bus.locked      = locked_q;
    assign bus.best_fcw    = best_fcw_q;
    assign bus.best_energy = best_energy_q;
endmodule
